// File: rtl/atom_rf_pkg.sv
// Shared constants for the Atom integer register file: write-port roles,
// the hard-wired zero register index and the register-count helper.
package atom_rf_pkg;

  localparam int unsigned WP_ALU  = 32'd0;
  localparam int unsigned WP_LATE = 32'd1;
  localparam int unsigned R0_IDX  = 32'd0;

  function automatic int unsigned reg_count(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for pending late writes: reserve sets a bit,
// a late-port write clears it, and reserve wins a same-cycle race.
module rf_scoreboard
  import atom_rf_pkg::*;
#(
  parameter  int unsigned REG_ADDR_WIDTH = 5,
  parameter  bit          R0_IS_ZERO     = 1'b1,
  localparam int unsigned REG_COUNT      = reg_count(REG_ADDR_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] clr_sel_i,
  input  logic                      rsv_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] rsv_sel_i,
  output logic [REG_COUNT-1:0]      busy_vec_o,
  output logic                      rsv_conflict_o
);

  localparam logic [REG_ADDR_WIDTH-1:0] R0_SEL  = REG_ADDR_WIDTH'(R0_IDX);
  localparam logic [REG_COUNT-1:0]      ONE_HOT = REG_COUNT'(1);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic                 conflict_q, conflict_d;
  logic                 clr_eff_s, rsv_eff_s;
  logic [REG_COUNT-1:0] clr_mask_s, set_mask_s;

  // Next busy vector and conflict pulse; set is applied after clear so reserve wins.
  always_comb begin
    clr_eff_s  = clr_valid_i && !(R0_IS_ZERO && (clr_sel_i == R0_SEL));
    rsv_eff_s  = rsv_valid_i && !(R0_IS_ZERO && (rsv_sel_i == R0_SEL));
    clr_mask_s = clr_eff_s ? (ONE_HOT << clr_sel_i) : {REG_COUNT{1'b0}};
    set_mask_s = rsv_eff_s ? (ONE_HOT << rsv_sel_i) : {REG_COUNT{1'b0}};
    busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
    conflict_d = rsv_eff_s && busy_q[rsv_sel_i] &&
                 !(clr_eff_s && (clr_sel_i == rsv_sel_i));
  end

  // Busy and conflict state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= {REG_COUNT{1'b0}};
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_vec_o     = busy_q;
  assign rsv_conflict_o = conflict_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the Atom core: N read ports, an early
// ALU and a late writeback port, optional bypass/registered reads, busy scoreboard.
module regfile_mp
  import atom_rf_pkg::*;
#(
  parameter  int unsigned REG_WIDTH      = 32,
  parameter  int unsigned REG_ADDR_WIDTH = 5,
  parameter  int unsigned NUM_RD_PORTS   = 2,
  parameter  bit          R0_IS_ZERO     = 1'b1,
  parameter  bit          WR_BYPASS      = 1'b1,
  parameter  bit          SYNC_READ      = 1'b0,
  localparam int unsigned AW             = REG_ADDR_WIDTH,
  localparam int unsigned REG_COUNT      = reg_count(REG_ADDR_WIDTH)
) (
  input  logic                           Clk_i,
  input  logic                           Rst_ni,
  input  logic [NUM_RD_PORTS-1:0]        Rd_En_i,
  input  logic [NUM_RD_PORTS*AW-1:0]     Rd_Sel_i,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0] Rd_Data_o,
  output logic [NUM_RD_PORTS-1:0]        Rd_Busy_o,
  input  logic [1:0]                     Wr_We_i,
  input  logic [2*AW-1:0]                Wr_Sel_i,
  input  logic [2*REG_WIDTH-1:0]         Wr_Data_i,
  input  logic                           Rsv_Valid_i,
  input  logic [AW-1:0]                  Rsv_Sel_i,
  output logic                           Rsv_Conflict_o,
  output logic [REG_COUNT-1:0]           Busy_Vec_o
);

  localparam logic [AW-1:0] R0_SEL = AW'(R0_IDX);

  logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
  logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
  logic [1:0]           we_eff_s;
  logic [AW-1:0]        wsel_s  [2];
  logic [REG_WIDTH-1:0] wdata_s [2];

  // Unpack write ports; writes to the zero register are dropped here.
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      wsel_s[k]   = Wr_Sel_i[k*AW +: AW];
      wdata_s[k]  = Wr_Data_i[k*REG_WIDTH +: REG_WIDTH];
      we_eff_s[k] = Wr_We_i[k] && !(R0_IS_ZERO && (wsel_s[k] == R0_SEL));
    end
  end

  // Post-write register image; the late port overrides the ALU port on collision.
  always_comb begin
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (we_eff_s[WP_LATE] && (wsel_s[WP_LATE] == AW'(i))) begin
        regs_d[i] = wdata_s[WP_LATE];
      end else if (we_eff_s[WP_ALU] && (wsel_s[WP_ALU] == AW'(i))) begin
        regs_d[i] = wdata_s[WP_ALU];
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= {REG_WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .R0_IS_ZERO     (R0_IS_ZERO)
  ) u_scoreboard (
    .clk_i          (Clk_i),
    .rst_ni         (Rst_ni),
    .clr_valid_i    (Wr_We_i[WP_LATE]),
    .clr_sel_i      (wsel_s[WP_LATE]),
    .rsv_valid_i    (Rsv_Valid_i),
    .rsv_sel_i      (Rsv_Sel_i),
    .busy_vec_o     (Busy_Vec_o),
    .rsv_conflict_o (Rsv_Conflict_o)
  );

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] sel_s;
    logic          is_r0_s;
    logic          hit_late_s;
    logic          busy_s;

    // Busy view: a same-cycle late write retires the pending state when bypassed.
    always_comb begin
      sel_s      = Rd_Sel_i[p*AW +: AW];
      is_r0_s    = R0_IS_ZERO && (sel_s == R0_SEL);
      hit_late_s = WR_BYPASS && we_eff_s[WP_LATE] && (wsel_s[WP_LATE] == sel_s);
      if (is_r0_s || hit_late_s) begin
        busy_s = 1'b0;
      end else begin
        busy_s = Busy_Vec_o[sel_s];
      end
    end

    assign Rd_Busy_o[p] = busy_s;

    if (SYNC_READ) begin : g_sync
      logic [REG_WIDTH-1:0] rd_q, rd_d;

      // Write-first capture when enabled, hold otherwise.
      always_comb begin
        if (!Rd_En_i[p]) begin
          rd_d = rd_q;
        end else if (is_r0_s) begin
          rd_d = {REG_WIDTH{1'b0}};
        end else begin
          rd_d = regs_d[sel_s];
        end
      end

      // Registered read data.
      always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
          rd_q <= {REG_WIDTH{1'b0}};
        end else begin
          rd_q <= rd_d;
        end
      end

      assign Rd_Data_o[p*REG_WIDTH +: REG_WIDTH] = rd_q;
    end else begin : g_async
      logic                 unused_en_s;
      logic                 hit_alu_s;
      logic [REG_WIDTH-1:0] data_s;

      assign unused_en_s = Rd_En_i[p];

      // Combinational read with optional forwarding of same-cycle writes.
      always_comb begin
        hit_alu_s = WR_BYPASS && we_eff_s[WP_ALU] && (wsel_s[WP_ALU] == sel_s);
        if (is_r0_s) begin
          data_s = {REG_WIDTH{1'b0}};
        end else if (hit_late_s) begin
          data_s = wdata_s[WP_LATE];
        end else if (hit_alu_s) begin
          data_s = wdata_s[WP_ALU];
        end else begin
          data_s = regs_q[sel_s];
        end
      end

      assign Rd_Data_o[p*REG_WIDTH +: REG_WIDTH] = data_s;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: an async-read 2-port instance and a
// registered-read 3-port instance driven with hand-computed vectors.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_sel;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_we;
  logic [9:0]  a_wsel;
  logic [63:0] a_wdata;
  logic        a_rsv_v;
  logic [4:0]  a_rsv_sel;
  logic        a_conf;
  logic [31:0] a_busy_vec;

  logic [2:0]  s_rd_en;
  logic [14:0] s_rd_sel;
  logic [95:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic [1:0]  s_we;
  logic [9:0]  s_wsel;
  logic [63:0] s_wdata;
  logic        s_rsv_v;
  logic [4:0]  s_rsv_sel;
  logic        s_conf;
  logic [31:0] s_busy_vec;

  int n_cmp;
  int n_err;

  regfile_mp #(
    .NUM_RD_PORTS (2),
    .R0_IS_ZERO   (1'b1),
    .WR_BYPASS    (1'b1),
    .SYNC_READ    (1'b0)
  ) dut_a (
    .Clk_i          (clk),
    .Rst_ni         (rst_n),
    .Rd_En_i        (a_rd_en),
    .Rd_Sel_i       (a_rd_sel),
    .Rd_Data_o      (a_rd_data),
    .Rd_Busy_o      (a_rd_busy),
    .Wr_We_i        (a_we),
    .Wr_Sel_i       (a_wsel),
    .Wr_Data_i      (a_wdata),
    .Rsv_Valid_i    (a_rsv_v),
    .Rsv_Sel_i      (a_rsv_sel),
    .Rsv_Conflict_o (a_conf),
    .Busy_Vec_o     (a_busy_vec)
  );

  regfile_mp #(
    .NUM_RD_PORTS (3),
    .R0_IS_ZERO   (1'b1),
    .WR_BYPASS    (1'b1),
    .SYNC_READ    (1'b1)
  ) dut_s (
    .Clk_i          (clk),
    .Rst_ni         (rst_n),
    .Rd_En_i        (s_rd_en),
    .Rd_Sel_i       (s_rd_sel),
    .Rd_Data_o      (s_rd_data),
    .Rd_Busy_o      (s_rd_busy),
    .Wr_We_i        (s_we),
    .Wr_Sel_i       (s_wsel),
    .Wr_Data_i      (s_wdata),
    .Rsv_Valid_i    (s_rsv_v),
    .Rsv_Sel_i      (s_rsv_sel),
    .Rsv_Conflict_o (s_conf),
    .Busy_Vec_o     (s_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_rd_en = 2'b00; a_rd_sel = 10'd0; a_we = 2'b00; a_wsel = 10'd0;
    a_wdata = 64'd0; a_rsv_v = 1'b0; a_rsv_sel = 5'd0;
    s_rd_en = 3'b000; s_rd_sel = 15'd0; s_we = 2'b00; s_wsel = 10'd0;
    s_wdata = 64'd0; s_rsv_v = 1'b0; s_rsv_sel = 5'd0;

    #3;
    check_eq("rst_busy_vec", {32'd0, a_busy_vec}, 64'd0);
    check_eq("rst_conflict", {63'd0, a_conf}, 64'd0);
    check_eq("rst_sync_data", s_rd_data[63:0], 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Write r5 and reserve r6, then reset asynchronously mid-cycle.
    a_we = 2'b01; a_wsel = {5'd0, 5'd5}; a_wdata = {32'd0, 32'hDEADBEEF};
    a_rsv_v = 1'b1; a_rsv_sel = 5'd6;
    tick();
    a_we = 2'b00; a_rsv_v = 1'b0; a_rd_sel = {5'd0, 5'd5};
    #1;
    check_eq("r5_written", {32'd0, a_rd_data[31:0]}, 64'hDEADBEEF);
    check_eq("r6_busy", {32'd0, a_busy_vec}, 64'h40);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_r5", {32'd0, a_rd_data[31:0]}, 64'd0);
    check_eq("async_rst_busy", {32'd0, a_busy_vec}, 64'd0);
    #1 rst_n = 1'b1;
    tick();

    // r0 write and reserve are both dropped.
    a_we = 2'b01; a_wsel = {5'd0, 5'd0}; a_wdata = {32'd0, 32'h1234};
    a_rsv_v = 1'b1; a_rsv_sel = 5'd0; a_rd_sel = {5'd0, 5'd0};
    #1;
    check_eq("r0_no_bypass", {32'd0, a_rd_data[31:0]}, 64'd0);
    tick();
    a_we = 2'b00; a_rsv_v = 1'b0;
    #1;
    check_eq("r0_read", {32'd0, a_rd_data[31:0]}, 64'd0);
    check_eq("r0_busy", {62'd0, a_rd_busy}, 64'd0);
    check_eq("r0_busy_vec", {32'd0, a_busy_vec}, 64'd0);
    check_eq("r0_conflict", {63'd0, a_conf}, 64'd0);

    // Both ports write r7: late port wins, also on the bypass path.
    a_we = 2'b11; a_wsel = {5'd7, 5'd7}; a_wdata = {32'h5555, 32'hAAAA};
    a_rd_sel = {5'd0, 5'd7};
    #1;
    check_eq("r7_bypass", {32'd0, a_rd_data[31:0]}, 64'h5555);
    check_eq("r7_bypass_busy", {63'd0, a_rd_busy[0]}, 64'd0);
    tick();
    a_we = 2'b00;
    #1;
    check_eq("r7_collision", {32'd0, a_rd_data[31:0]}, 64'h5555);

    // ALU-port bypass on port 1 while port 0 independently reads r7.
    a_we = 2'b01; a_wsel = {5'd0, 5'd8}; a_wdata = {32'd0, 32'h77};
    a_rd_sel = {5'd8, 5'd7};
    #1;
    check_eq("r8_alu_bypass", {32'd0, a_rd_data[63:32]}, 64'h77);
    check_eq("r7_indep", {32'd0, a_rd_data[31:0]}, 64'h5555);
    tick();
    a_we = 2'b00;
    #1;
    check_eq("r8_stored", {32'd0, a_rd_data[63:32]}, 64'h77);

    // Scoreboard: reserve r3, re-reserve for conflict, late write clears.
    a_rsv_v = 1'b1; a_rsv_sel = 5'd3;
    tick();
    a_rsv_v = 1'b0; a_rd_sel = {5'd0, 5'd3};
    #1;
    check_eq("r3_busy", {63'd0, a_rd_busy[0]}, 64'd1);
    check_eq("r3_no_conflict", {63'd0, a_conf}, 64'd0);
    check_eq("r3_busy_vec", {32'd0, a_busy_vec}, 64'h8);
    a_rsv_v = 1'b1;
    tick();
    a_rsv_v = 1'b0;
    #1;
    check_eq("r3_conflict", {63'd0, a_conf}, 64'd1);
    check_eq("r3_still_busy", {63'd0, a_rd_busy[0]}, 64'd1);
    tick();
    check_eq("r3_conflict_pulse", {63'd0, a_conf}, 64'd0);
    a_we = 2'b10; a_wsel = {5'd3, 5'd0}; a_wdata = {32'h42, 32'd0};
    #1;
    check_eq("r3_late_bypass", {32'd0, a_rd_data[31:0]}, 64'h42);
    check_eq("r3_late_bypass_busy", {63'd0, a_rd_busy[0]}, 64'd0);
    tick();
    a_we = 2'b00;
    #1;
    check_eq("r3_cleared", {32'd0, a_busy_vec}, 64'd0);
    check_eq("r3_data", {32'd0, a_rd_data[31:0]}, 64'h42);

    // ALU-port write to a busy register leaves it busy.
    a_rsv_v = 1'b1; a_rsv_sel = 5'd10;
    tick();
    a_rsv_v = 1'b0;
    a_we = 2'b01; a_wsel = {5'd0, 5'd10}; a_wdata = {32'd0, 32'h99};
    a_rd_sel = {5'd10, 5'd0};
    #1;
    check_eq("r10_alu_bypass", {32'd0, a_rd_data[63:32]}, 64'h99);
    check_eq("r10_alu_busy", {63'd0, a_rd_busy[1]}, 64'd1);
    tick();
    a_we = 2'b00;
    #1;
    check_eq("r10_busy_vec", {32'd0, a_busy_vec}, 64'h400);

    // Reserve of a busy register cleared in the same cycle: no conflict.
    a_rsv_v = 1'b1; a_rsv_sel = 5'd10;
    a_we = 2'b10; a_wsel = {5'd10, 5'd0}; a_wdata = {32'hCAFE, 32'd0};
    tick();
    a_rsv_v = 1'b0; a_we = 2'b00;
    #1;
    check_eq("r10_race_conflict", {63'd0, a_conf}, 64'd0);
    check_eq("r10_race_busy", {32'd0, a_busy_vec}, 64'h400);
    check_eq("r10_race_data", {32'd0, a_rd_data[63:32]}, 64'hCAFE);

    // Set/clear race on an idle register: reserve wins.
    a_rsv_v = 1'b1; a_rsv_sel = 5'd9;
    a_we = 2'b10; a_wsel = {5'd9, 5'd0}; a_wdata = {32'hBEEF, 32'd0};
    a_rd_sel = {5'd10, 5'd9};
    tick();
    a_rsv_v = 1'b0; a_we = 2'b00;
    #1;
    check_eq("r9_race_busy_vec", {32'd0, a_busy_vec}, 64'h600);
    check_eq("r9_race_data", {32'd0, a_rd_data[31:0]}, 64'hBEEF);
    check_eq("r9_race_rd_busy", {63'd0, a_rd_busy[0]}, 64'd1);
    check_eq("r9_race_conflict", {63'd0, a_conf}, 64'd0);

    // Registered reads: write-first capture, then hold on disabled port.
    s_we = 2'b01; s_wsel = {5'd0, 5'd4}; s_wdata = {32'd0, 32'h10};
    s_rd_en = 3'b111; s_rd_sel = {5'd4, 5'd4, 5'd4};
    #1;
    check_eq("sync_latency", {32'd0, s_rd_data[31:0]}, 64'd0);
    tick();
    s_we = 2'b00;
    #1;
    check_eq("sync_p0_first", {32'd0, s_rd_data[31:0]}, 64'h10);
    check_eq("sync_p1_first", {32'd0, s_rd_data[63:32]}, 64'h10);
    check_eq("sync_p2_first", {32'd0, s_rd_data[95:64]}, 64'h10);
    s_rd_en = 3'b101;
    s_we = 2'b01; s_wdata = {32'd0, 32'h20};
    tick();
    s_we = 2'b00;
    #1;
    check_eq("sync_p0_new", {32'd0, s_rd_data[31:0]}, 64'h20);
    check_eq("sync_p1_hold", {32'd0, s_rd_data[63:32]}, 64'h10);
    check_eq("sync_p2_new", {32'd0, s_rd_data[95:64]}, 64'h20);
    s_rsv_v = 1'b1; s_rsv_sel = 5'd4;
    tick();
    s_rsv_v = 1'b0;
    #1;
    check_eq("sync_rd_busy", {61'd0, s_rd_busy}, 64'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the Atom core, the successor to the 2R/1W register file. It provides N read ports, two write ports (port 0 for early ALU writeback, port 1 for late load/long-latency writeback), optional write-to-read bypass, optional registered reads, and a per-register busy scoreboard. The scoreboard lets the decode stage detect pending late writes. It sits between decode (reads, reserve) and writeback (writes).

Parameters:
REG_WIDTH, 32, data width of each register
REG_ADDR_WIDTH, 5, select width; REG_COUNT = 2**REG_ADDR_WIDTH
NUM_RD_PORTS, 2, number of read ports (1..4)
R0_IS_ZERO, 1, 1: r0 reads as 0, writes and reserves to r0 are dropped
WR_BYPASS, 1, 1: same-cycle write data is forwarded to the read outputs
SYNC_READ, 0, 0: asynchronous read; 1: read data registered, 1-cycle latency

Ports:
Clk_i  in  1  clock, rising edge
Rst_ni  in  1  asynchronous active-low reset
Rd_En_i  in  NUM_RD_PORTS  per-port read enable (used only when SYNC_READ=1)
Rd_Sel_i  in  NUM_RD_PORTS*REG_ADDR_WIDTH  packed read selects, port p at [p*AW +: AW]
Rd_Data_o  out  NUM_RD_PORTS*REG_WIDTH  packed read data
Rd_Busy_o  out  NUM_RD_PORTS  selected register has a pending late write
Wr_We_i  in  2  write enables, bit k = write port k
Wr_Sel_i  in  2*REG_ADDR_WIDTH  write selects
Wr_Data_i  in  2*REG_WIDTH  write data
Rsv_Valid_i  in  1  reserve request: mark Rsv_Sel_i busy
Rsv_Sel_i  in  REG_ADDR_WIDTH  register to reserve
Rsv_Conflict_o  out  1  registered 1-cycle pulse: reserve hit a register that was already busy
Busy_Vec_o  out  2**REG_ADDR_WIDTH  current busy bits, for debug/trace

Behaviour:
- Reset (Rst_ni low, asynchronous): all registers 0, all busy bits 0, Rsv_Conflict_o 0, registered Rd_Data_o 0. Operation resumes at the first edge after deassertion. A reset asserted mid-operation discards pending writes and reservations.
- Write, on posedge: for port k with Wr_We_i[k], regs[sel_k] <= data_k. When R0_IS_ZERO=1 and sel_k=0, the write is dropped.
- Both write ports targeting the same register in one cycle: port 1 wins. Port 0's write to that register is lost.
- Busy clear: a port 1 write clears busy[sel_1]. A port 0 write never changes busy.
- Busy set: Rsv_Valid_i sets busy[Rsv_Sel_i]. Dropped for r0 when R0_IS_ZERO=1.
- Reserve and port 1 clear on the same register in the same cycle: busy ends at 1 (reserve wins).
- Rsv_Conflict_o: asserted for one cycle after a reserve whose target busy bit was 1 before the edge and was not cleared in that same cycle. The register stays busy.
- Read, SYNC_READ=0 (combinational):
  - R0_IS_ZERO=1 and sel=0: data 0, busy 0.
  - Otherwise, with WR_BYPASS=1 and a same-cycle write to sel: output the write data (port 1 beats port 0), and Rd_Busy_o is 0 when that write is on port 1.
  - Otherwise: regs[sel] and busy[sel].
- Read, SYNC_READ=1: at posedge with Rd_En_i[p], Rd_Data_o[p] captures the post-write value of regs[sel] (write-first; WR_BYPASS is ignored). With Rd_En_i[p] low, Rd_Data_o[p] holds its value. Rd_Busy_o stays combinational on the current select, same rule as above.
- Each read port decodes only its own select; ports are fully independent.
- Zero-extension and width: selects are unsigned, and every REG_COUNT entry exists.

Decomposition:
- Shared package atom_rf_pkg: REG_COUNT function, the r0 index constant, and write port indices WP_ALU=0 and WP_LATE=1.
- Natural sub-module: rf_scoreboard. It holds the busy vector, set/clear priority and conflict pulse; instantiated once.
- The read mux/bypass is a generate loop over NUM_RD_PORTS inside regfile_mp.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert Rst_ni low asynchronously mid-cycle -> Rd_Data_o for r5 reads 0 immediately; Busy_Vec_o = 0.
- R0: write 0x1234 to r0 via port 0 and reserve r0 (R0_IS_ZERO=1) -> r0 reads 0, busy[0] = 0, no conflict pulse.
- Write collision: same cycle port 0 writes r7=0xAAAA and port 1 writes r7=0x5555 -> next cycle r7 = 0x5555. With WR_BYPASS=1, a same-cycle read of r7 returns 0x5555.
- Scoreboard: reserve r3 -> Rd_Busy_o=1 on r3. Reserve r3 again -> Rsv_Conflict_o=1 for exactly one cycle. Port 1 writes r3=0x42 -> bypassed read shows 0x42 with busy 0; busy[3] = 0 next cycle.
- Set/clear race: same cycle port 1 writes r9 and reserve r9 -> busy[9] = 1 afterwards, data = written value.
- SYNC_READ=1, NUM_RD_PORTS=3: write r4=0x10 and enable all three ports reading r4 in the same cycle -> all outputs 0x10 one cycle later. Drop Rd_En_i[1] and write r4=0x20 -> port 1 holds 0x10, ports 0 and 2 show 0x20.
